uart_tx: RTL and testbench

Serial UART transmitter that produces the line format consumed by the team's UART receiver. Each frame is one start bit (0), eight data bits LSB first, an optional even-parity bit, and one stop bit (1). Every bit is held for `CLK_PER_BIT` clocks. A one-entry holding buffer in front of the shift register lets a producer queue the next byte while the current frame is on the line, so back-to-back frames go out with no idle gap.

---
 rtl/uart_tx.sv | 177 +++++++++++++++++
 tb/tb_uart_tx.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/uart_tx.sv
// UART transmitter: start, 8 data bits LSB first, optional even parity, stop.
// Define UART_TX_PARITY_EN to compile in the parity bit (11-bit frames); otherwise frames are 10 bits.
module uart_tx #(
  parameter int unsigned CLK_PER_BIT = 87
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       i_tx_valid,
  input  logic [7:0] i_tx_data,
  output logic       o_tx_ready,
  output logic       o_tx_serial,
  output logic       o_tx_active,
  output logic       o_tx_done
);

  localparam int unsigned CNT_W = 8;
  localparam int unsigned IND_W = 3;
  localparam logic [CNT_W-1:0] TERM_CNT = CNT_W'(CLK_PER_BIT - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [7:0]       r_buf;
  logic             r_buf_valid;
  logic [7:0]       r_shift;
  logic [CNT_W-1:0] r_bit_cnt;
  logic [IND_W-1:0] r_bit_ind;
  logic             r_serial;
  logic             r_active;
  logic             r_done;
  logic             r_ready;

  logic [7:0]       w_shift_nxt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic [IND_W-1:0] w_ind_nxt;
  logic             w_buf_valid_nxt;
  logic             w_drain;
  logic             w_accept;
  logic             w_term;
  logic             w_done_nxt;
  logic             w_serial_nxt;

  assign w_accept = i_tx_valid && !r_buf_valid;
  assign w_term   = (r_bit_cnt == TERM_CNT);

  // Next state, counters and buffer drain.
  always_comb begin
    w_state_nxt = r_state;
    w_shift_nxt = r_shift;
    w_cnt_nxt   = r_bit_cnt + CNT_W'(1);
    w_ind_nxt   = r_bit_ind;
    w_drain     = 1'b0;
    w_done_nxt  = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_cnt_nxt = '0;
        if (r_buf_valid) begin
          w_drain     = 1'b1;
          w_shift_nxt = r_buf;
          w_state_nxt = S_START;
        end
      end
      S_START: begin
        if (w_term) begin
          w_cnt_nxt   = '0;
          w_ind_nxt   = '0;
          w_state_nxt = S_DATA;
        end
      end
      S_DATA: begin
        if (w_term) begin
          w_cnt_nxt = '0;
          if (r_bit_ind == IND_W'(7)) begin
            w_ind_nxt = '0;
`ifdef UART_TX_PARITY_EN
            w_state_nxt = S_PARITY;
`else
            w_state_nxt = S_STOP;
`endif
          end else begin
            w_ind_nxt = r_bit_ind + IND_W'(1);
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      S_PARITY: begin
        if (w_term) begin
          w_cnt_nxt   = '0;
          w_state_nxt = S_STOP;
        end
      end
`endif
      S_STOP: begin
        if (w_term) begin
          w_cnt_nxt  = '0;
          w_done_nxt = 1'b1;
          if (r_buf_valid) begin
            w_drain     = 1'b1;
            w_shift_nxt = r_buf;
            w_state_nxt = S_START;
          end else begin
            w_state_nxt = S_IDLE;
          end
        end
      end
      default: begin
        w_cnt_nxt   = '0;
        w_ind_nxt   = '0;
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // Drain and accept are mutually exclusive: drain needs a full buffer, accept an empty one.
  always_comb begin
    w_buf_valid_nxt = r_buf_valid;
    if (w_drain) begin
      w_buf_valid_nxt = 1'b0;
    end else if (w_accept) begin
      w_buf_valid_nxt = 1'b1;
    end
  end

  // Line level for the state being entered, so the registered output lines up with the state.
  always_comb begin
    w_serial_nxt = 1'b1;
    case (w_state_nxt)
      S_START:  w_serial_nxt = 1'b0;
      S_DATA:   w_serial_nxt = w_shift_nxt[w_ind_nxt];
`ifdef UART_TX_PARITY_EN
      S_PARITY: w_serial_nxt = ^w_shift_nxt;
`endif
      default:  w_serial_nxt = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_buf       <= '0;
      r_buf_valid <= 1'b0;
      r_shift     <= '0;
      r_bit_cnt   <= '0;
      r_bit_ind   <= '0;
      r_serial    <= 1'b1;
      r_active    <= 1'b0;
      r_done      <= 1'b0;
      r_ready     <= 1'b1;
    end else begin
      r_state     <= w_state_nxt;
      r_buf_valid <= w_buf_valid_nxt;
      r_shift     <= w_shift_nxt;
      r_bit_cnt   <= w_cnt_nxt;
      r_bit_ind   <= w_ind_nxt;
      r_serial    <= w_serial_nxt;
      r_active    <= (w_state_nxt != S_IDLE);
      r_done      <= w_done_nxt;
      r_ready     <= !w_buf_valid_nxt;
      if (w_accept) begin
        r_buf <= i_tx_data;
      end
    end
  end

  assign o_tx_ready  = r_ready;
  assign o_tx_serial = r_serial;
  assign o_tx_active = r_active;
  assign o_tx_done   = r_done;

endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx at CLK_PER_BIT=8; frame expectations follow UART_TX_PARITY_EN.
module tb_uart_tx;

  localparam int unsigned CPB = 8;
`ifdef UART_TX_PARITY_EN
  localparam int NB = 11;
`else
  localparam int NB = 10;
`endif

  logic       clk = 1'b0;
  logic       reset;
  logic       i_tx_valid;
  logic [7:0] i_tx_data;
  logic       o_tx_ready;
  logic       o_tx_serial;
  logic       o_tx_active;
  logic       o_tx_done;

  int checks   = 0;
  int failures = 0;

  uart_tx #(.CLK_PER_BIT(CPB)) dut (
    .clk         (clk),
    .reset       (reset),
    .i_tx_valid  (i_tx_valid),
    .i_tx_data   (i_tx_data),
    .o_tx_ready  (o_tx_ready),
    .o_tx_serial (o_tx_serial),
    .o_tx_active (o_tx_active),
    .o_tx_done   (o_tx_done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Present a byte at a negedge, wait (bounded) for ready, return at the negedge after acceptance.
  task automatic send(input logic [7:0] d, input string name);
    int waited;
    waited = 0;
    @(negedge clk);
    while (!o_tx_ready && waited < 2000) begin
      @(negedge clk);
      waited++;
    end
    check({name, " ready_wait"}, 32'(o_tx_ready), 32'd1);
    i_tx_valid = 1'b1;
    i_tx_data  = d;
    @(posedge clk);
    #1;
    check({name, " ready_after_accept"}, 32'(o_tx_ready), 32'd0);
    @(negedge clk);
    i_tx_valid = 1'b0;
    i_tx_data  = 8'h00;
  endtask

  // Sample every cycle of one frame, starting at the next posedge.
  task automatic expect_frame(input logic [7:0] d, input logic par, input logic done_first,
                              input string name);
    logic [10:0] bits;
    logic s0, sl;
    int act_err, done_err;
    bits = '1;
    bits[0] = 1'b0;
    for (int i = 0; i < 8; i++) bits[i+1] = d[i];
    bits[9] = par;
    bits[NB-1] = 1'b1;
    act_err = 0;
    done_err = 0;
    s0 = 1'b0;
    sl = 1'b0;
    for (int b = 0; b < NB; b++) begin
      for (int c = 0; c < int'(CPB); c++) begin
        @(posedge clk);
        #1;
        if (b == 0 && c == 0) begin
          check({name, " done_at_start"}, 32'(o_tx_done), 32'(done_first));
          check({name, " ready_at_start"}, 32'(o_tx_ready), 32'd1);
        end else if (o_tx_done) begin
          done_err++;
        end
        if (!o_tx_active) act_err++;
        if (c == 0) s0 = o_tx_serial;
        if (c == int'(CPB) - 1) sl = o_tx_serial;
      end
      check($sformatf("%s bit%0d first", name, b), 32'(s0), 32'(bits[b]));
      check($sformatf("%s bit%0d last", name, b), 32'(sl), 32'(bits[b]));
    end
    check({name, " active_low_in_frame"}, 32'(act_err), 32'd0);
    check({name, " done_early"}, 32'(done_err), 32'd0);
  endtask

  task automatic expect_tail(input string name);
    @(posedge clk);
    #1;
    check({name, " done_pulse"}, 32'(o_tx_done), 32'd1);
    check({name, " idle_line"}, 32'(o_tx_serial), 32'd1);
    check({name, " idle_active"}, 32'(o_tx_active), 32'd0);
    @(posedge clk);
    #1;
    check({name, " done_one_cycle"}, 32'(o_tx_done), 32'd0);
  endtask

  logic [7:0] vec_data [4] = '{8'hA5, 8'h07, 8'h03, 8'h81};
  logic       vec_par  [4] = '{1'b0, 1'b1, 1'b0, 1'b0};

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    reset      = 1'b1;
    i_tx_valid = 1'b0;
    i_tx_data  = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    check("rst serial", 32'(o_tx_serial), 32'd1);
    check("rst ready", 32'(o_tx_ready), 32'd1);
    check("rst active", 32'(o_tx_active), 32'd0);
    check("rst done", 32'(o_tx_done), 32'd0);
    @(negedge clk);
    reset = 1'b0;

    // Single frames: A5 line pattern, parity of 0x07 / 0x03, 0x81.
    for (int v = 0; v < 4; v++) begin
      send(vec_data[v], $sformatf("v%0d", v));
      expect_frame(vec_data[v], vec_par[v], 1'b0, $sformatf("v%0d", v));
      expect_tail($sformatf("v%0d", v));
    end

    // Back-to-back: 0xFF queued during the 0x00 frame, no idle gap.
    send(8'h00, "b2b0");
    fork
      expect_frame(8'h00, 1'b0, 1'b0, "b2b0");
      begin
        repeat (20) @(negedge clk);
        send(8'hFF, "b2b1q");
        repeat (10) @(negedge clk);
        check("b2b ready_low_while_buffered", 32'(o_tx_ready), 32'd0);
      end
    join
    expect_frame(8'hFF, 1'b0, 1'b1, "b2b1");
    expect_tail("b2b1");

    // Reset mid-frame with a byte queued.
    send(8'h5A, "rst0");
    repeat (5) @(negedge clk);
    send(8'h5B, "rst1q");
    repeat (20) @(negedge clk);
    reset = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk);
      #1;
      check($sformatf("midrst%0d serial", k), 32'(o_tx_serial), 32'd1);
      check($sformatf("midrst%0d ready", k), 32'(o_tx_ready), 32'd1);
      check($sformatf("midrst%0d active", k), 32'(o_tx_active), 32'd0);
      check($sformatf("midrst%0d done", k), 32'(o_tx_done), 32'd0);
    end
    @(negedge clk);
    reset = 1'b0;
    repeat (4 * CPB) @(posedge clk);
    #1;
    check("postrst serial", 32'(o_tx_serial), 32'd1);
    check("postrst active_discard", 32'(o_tx_active), 32'd0);
    check("postrst done", 32'(o_tx_done), 32'd0);

    // Transmitter still works after the reset.
    send(8'h3C, "after");
    expect_frame(8'h3C, 1'b0, 1'b0, "after");
    expect_tail("after");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
